demux8_buf: RTL and testbench
=============================

Name: demux8_buf

Overview:
- 1-to-4 byte demultiplexer. It routes an 8-bit input stream to one of four output channels (y0..y3) chosen by a 2-bit select.
- Each channel has its own small FIFO and a valid/ready handshake.
- It sits on the write side of the 4:1 byte-mux datapath: it distributes the bytes that the mux path later recombines.
- Slow consumers on one channel do not corrupt data on the others.

Parameters:
- W, 8, data width per channel.
- DEPTH, 2, entries per channel FIFO. Must be a power of two, ≥2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- din  input  W  input byte.
- s  input  2  channel select: 0→y0, 1→y1, 2→y2, 3→y3.
- in_valid  input  1  din/s valid.
- in_ready  output  1  block can accept din on the channel currently selected.
- y0,y1,y2,y3  output  W  head-of-FIFO data for each channel.
- v  output  4  v[n] = channel n has data.
- r  input  4  r[n] = consumer n takes y<n> this cycle.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - All counts, read pointers and write pointers go to 0.
  - v=4'b0000, y0..y3=0.
  - in_ready goes to 1 on the first cycle after reset is released.
  - Reset mid-transfer discards all buffered data. No partial state survives.
- Per channel n:
  - Circular FIFO of DEPTH×W.
  - Write pointer and read pointer are each log2(DEPTH) bits and wrap modulo DEPTH.
  - cnt is log2(DEPTH)+1 bits, range 0..DEPTH.
- Outputs:
  - v[n] = (cnt_n != 0).
  - y<n> = mem_n[rdptr_n] when v[n]=1, else 0. This is combinational from registered state.
- in_ready:
  - Combinational: in_ready = (cnt_sel != DEPTH), where sel = current s.
  - It depends only on s and state, never on in_valid or r.
- Push:
  - Occurs at a rising edge when in_valid & in_ready.
  - din is written to channel s; that channel's write pointer and cnt increment.
- Pop:
  - Occurs at a rising edge when v[n] & r[n].
  - That channel's read pointer increments and its cnt decrements.
  - r[n] while v[n]=0 is ignored: no underflow and no pointer change.
- Latency: a byte accepted at edge k appears on y<s> with v[s]=1 after edge k (one cycle). There is no same-cycle bypass.
- Simultaneous push and pop on the same channel with 0<cnt<DEPTH: cnt is unchanged and both pointers advance.
- Full channel: in_ready=0 even if r[sel]=1 in that cycle. There is no full-pass-through, which keeps timing and verification deterministic.
- Channels are independent: pops on all four channels plus one push can occur in the same cycle.
- Select change while in_valid=1 and not accepted:
  - Allowed.
  - in_ready re-evaluates against the new s.
  - Source protocol: the source must hold din and s stable until accepted.
- Ordering: per-channel FIFO order is strictly preserved. No ordering is guaranteed across channels.

Optional Feature:
- Macro DEMUX8_BCAST_EN.
- Defined:
  - Adds input port bcast (1 bit).
  - When bcast=1, s is ignored and in_ready = all four channels not full.
  - An accepted byte is pushed into all four FIFOs in the same edge.
  - When bcast=0, behaviour is identical to the base block.
- Undefined: the port is absent and there is no broadcast logic.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles, with in_valid=1 and din=8'hFF during reset.
   - Expect v=0000, y0..y3=00, and no push.
   - After release, expect in_ready=1.
2. Routing: push 8'hA1/s=0, 8'hB2/s=1, 8'hC3/s=2, 8'hD4/s=3 on consecutive cycles with r=0000.
   - Expect v=1111 and y0=A1, y1=B2, y2=C3, y3=D4.
   - Each v bit rises one cycle after its push.
3. Full/backpressure: with DEPTH=2 and r=0000, push 8'h11 then 8'h22 to s=2, then attempt 8'h33.
   - Expect in_ready=0 on the third attempt.
   - Then assert r[2] for 1 cycle: y2 goes 11→22, and in_ready returns to 1 in the following cycle.
   - 8'h33 is accepted only after that; the final sequence popped is 11, 22, 33.
4. Simultaneous push/pop and wrap: stream 8'h00..8'h0F to s=1 with r[1]=1 continuously.
   - Expect cnt to stay at 1 after the first push and v[1] to stay at 1.
   - Output order is 00..0F with no loss; pointers wrap 8 times.
5. Reset mid-operation: fill channel 3 with 8'h5A and 8'h5B, pulse rst_n=0 for 1 cycle.
   - Expect v[3]=0 and y3=00.
   - The next push of 8'h77 is output first.
6. DEMUX8_BCAST_EN defined: bcast=1, din=8'hE7.
   - Expect y0..y3=E7 and v=1111 after one edge.
   - With channel 0 full, expect in_ready=0 and no channel written.

Source files
------------

// File: rtl/demux8_buf_if.sv
// Byte-stream handshake bundle for demux8_buf: one input stream, four output channels.
// The bcast wire exists only when DEMUX8_BCAST_EN is defined.
interface demux8_buf_if #(parameter int W = 8);
    logic [W-1:0] din;
    logic [1:0]   s;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] y0, y1, y2, y3;
    logic [3:0]   v;
    logic [3:0]   r;
`ifdef DEMUX8_BCAST_EN
    logic         bcast;

    modport master (output din, s, in_valid, r, bcast, input in_ready, y0, y1, y2, y3, v);
    modport slave  (input din, s, in_valid, r, bcast, output in_ready, y0, y1, y2, y3, v);
`else
    modport master (output din, s, in_valid, r, input in_ready, y0, y1, y2, y3, v);
    modport slave  (input din, s, in_valid, r, output in_ready, y0, y1, y2, y3, v);
`endif
endinterface

// File: rtl/demux8_buf.sv
// 1-to-4 byte demultiplexer with a small FIFO per output channel.
// Optional DEMUX8_BCAST_EN adds a bcast input that writes one byte into all four FIFOs.
module demux8_buf_ch #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop_req,
    output logic [W-1:0] dout,
    output logic         vld,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]             cnt_q, cnt_d;
    logic                    pop;

    assign vld  = (cnt_q != '0);
    assign full = (cnt_q == (AW+1)'(DEPTH));
    assign pop  = pop_req & vld;
    assign dout = vld ? mem_q[rd_q] : '0;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + AW'(1);
        end
        if (pop)
            rd_d = rd_q + AW'(1);
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

module demux8_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    demux8_buf_if.slave bus
);
    logic [3:0]        full, vld, push, sel_oh, tgt;
    logic [3:0][W-1:0] y;

    assign sel_oh = 4'b0001 << bus.s;
`ifdef DEMUX8_BCAST_EN
    assign tgt = bus.bcast ? 4'b1111 : sel_oh;
`else
    assign tgt = sel_oh;
`endif
    // Ready only when every targeted channel has room; in_valid and r never feed back here.
    assign bus.in_ready = ~|(full & tgt);
    assign push         = {4{bus.in_valid & bus.in_ready}} & tgt;

    for (genvar i = 0; i < 4; i++) begin : g_ch
        demux8_buf_ch #(.W(W), .DEPTH(DEPTH)) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .push    (push[i]),
            .din     (bus.din),
            .pop_req (bus.r[i]),
            .dout    (y[i]),
            .vld     (vld[i]),
            .full    (full[i])
        );
    end

    assign bus.v  = vld;
    assign bus.y0 = y[0];
    assign bus.y1 = y[1];
    assign bus.y2 = y[2];
    assign bus.y3 = y[3];
endmodule

// File: tb/tb_demux8_buf.sv
// Directed bench for demux8_buf: a per-channel queue scoreboard predicts ready, pops and heads.
module tb_demux8_buf;
    localparam int DEPTH = 2;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] mq [4][$];
    logic [7:0] yv [4];

    demux8_buf_if #(.W(8)) bus ();

    demux8_buf #(.W(8), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign yv[0] = bus.y0;
    assign yv[1] = bus.y1;
    assign yv[2] = bus.y2;
    assign yv[3] = bus.y3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; the model predicts ready before the edge and heads after it.
    task automatic step(input logic rn, input logic iv, input logic [7:0] d,
                        input logic [1:0] sel, input logic [3:0] rr, input logic bc);
        logic       exp_rdy;
        logic [3:0] ev;
        @(negedge clk);
        rst_n        = rn;
        bus.in_valid = iv;
        bus.din      = d;
        bus.s        = sel;
        bus.r        = rr;
`ifdef DEMUX8_BCAST_EN
        bus.bcast    = bc;
`endif
        #1;
        if (bc) begin
            exp_rdy = 1'b1;
            for (int n = 0; n < 4; n++)
                if (mq[n].size() >= DEPTH) exp_rdy = 1'b0;
        end else
            exp_rdy = (mq[sel].size() < DEPTH);
        if (rn) begin
            chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            for (int n = 0; n < 4; n++)
                if (rr[n] && mq[n].size() != 0)
                    chk($sformatf("pop_y%0d", n), 32'(yv[n]), 32'(mq[n][0]));
        end
        @(posedge clk);
        if (!rn) begin
            for (int n = 0; n < 4; n++) mq[n].delete();
        end else begin
            for (int n = 0; n < 4; n++)
                if (rr[n] && mq[n].size() != 0) void'(mq[n].pop_front());
            if (iv && exp_rdy) begin
                for (int n = 0; n < 4; n++)
                    if (bc || sel == 2'(n)) mq[n].push_back(d);
            end
        end
        #1;
        for (int n = 0; n < 4; n++) ev[n] = (mq[n].size() != 0);
        chk("v", 32'(bus.v), 32'(ev));
        for (int n = 0; n < 4; n++)
            chk($sformatf("head_y%0d", n), 32'(yv[n]), ev[n] ? 32'(mq[n][0]) : 32'h0);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.din      = '0;
        bus.s        = '0;
        bus.r        = '0;
`ifdef DEMUX8_BCAST_EN
        bus.bcast    = 1'b0;
`endif
        // Reset held two cycles with a live byte offered: nothing may be pushed.
        step(0, 1, 8'hFF, 2'd0, 4'b0000, 0);
        step(0, 1, 8'hFF, 2'd0, 4'b0000, 0);
        step(1, 0, 8'h00, 2'd0, 4'b0000, 0);

        // Routing to each channel.
        step(1, 1, 8'hA1, 2'd0, 4'b0000, 0);
        step(1, 1, 8'hB2, 2'd1, 4'b0000, 0);
        step(1, 1, 8'hC3, 2'd2, 4'b0000, 0);
        step(1, 1, 8'hD4, 2'd3, 4'b0000, 0);
        step(1, 0, 8'h00, 2'd0, 4'b1111, 0);

        // Fill channel 2, stall 33, release one slot, then drain.
        step(1, 1, 8'h11, 2'd2, 4'b0000, 0);
        step(1, 1, 8'h22, 2'd2, 4'b0000, 0);
        step(1, 1, 8'h33, 2'd2, 4'b0000, 0);
        step(1, 1, 8'h33, 2'd2, 4'b0100, 0);
        step(1, 1, 8'h33, 2'd2, 4'b0000, 0);
        step(1, 0, 8'h00, 2'd2, 4'b0100, 0);
        step(1, 0, 8'h00, 2'd2, 4'b0100, 0);

        // Continuous push/pop on channel 1 wraps the pointers.
        for (int i = 0; i < 16; i++)
            step(1, 1, 8'(i), 2'd1, 4'b0010, 0);
        step(1, 0, 8'h00, 2'd1, 4'b0010, 0);

        // Reset mid-operation discards buffered bytes.
        step(1, 1, 8'h5A, 2'd3, 4'b0000, 0);
        step(1, 1, 8'h5B, 2'd3, 4'b0000, 0);
        step(0, 0, 8'h00, 2'd3, 4'b0000, 0);
        step(1, 1, 8'h77, 2'd3, 4'b0000, 0);
        step(1, 0, 8'h00, 2'd3, 4'b1000, 0);

`ifdef DEMUX8_BCAST_EN
        step(1, 1, 8'hE7, 2'd2, 4'b0000, 1);
        step(1, 0, 8'h00, 2'd0, 4'b1111, 0);
        step(1, 1, 8'h01, 2'd0, 4'b0000, 0);
        step(1, 1, 8'h02, 2'd0, 4'b0000, 0);
        step(1, 1, 8'hE7, 2'd1, 4'b0000, 1);
        step(1, 0, 8'h00, 2'd0, 4'b1111, 0);
        step(1, 0, 8'h00, 2'd0, 4'b1111, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
